// File: rtl/sev_seg_display.sv
// sev_seg_display: free-running sequential binary-to-BCD converter for the
// seven-segment display path. A 32-bit unsigned value is converted with
// shift-add-3 (double-dabble) over 32 shift cycles. All ten digit codes are
// then registered together.
//
// Digit code: bits [3:0] hold the BCD digit, and bit [4] is the blank flag.
//
// Optional build macro SEV_SEG_BLANK_EN enables leading-zero blanking on
// D10..D2. D1 is never blanked. Without the macro, bit [4] is always 0.
//
// state  | meaning
// -------+-----------------------------------------------------------
// LOAD   | sample ALUoutput, clear BCD scratch and shift counter
// SHIFT  | 32 cycles of add-3 adjust followed by a 1-bit left shift
// UPDATE | register scratch nibbles (with blanking) into D1..D10

module sev_seg_display (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ALUoutput,
    output logic [4:0]  D1,
    output logic [4:0]  D2,
    output logic [4:0]  D3,
    output logic [4:0]  D4,
    output logic [4:0]  D5,
    output logic [4:0]  D6,
    output logic [4:0]  D7,
    output logic [4:0]  D8,
    output logic [4:0]  D9,
    output logic [4:0]  D10
);

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        SHIFT  = 2'd1,
        UPDATE = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] bin_q;
    logic [39:0] scratch_q;
    logic [39:0] scratch_adj;
    logic [4:0]  cnt_q;
    logic [4:0]  code_d [10];
    logic [4:0]  dig_q  [10];

    // State register; reset parks the FSM in LOAD so a conversion restarts cleanly
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: LOAD -> 32 x SHIFT -> UPDATE -> LOAD
    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD:    state_d = SHIFT;
            SHIFT:   state_d = (cnt_q == 5'd31) ? UPDATE : SHIFT;
            UPDATE:  state_d = LOAD;
            default: state_d = LOAD;
        endcase
    end

    // Add-3 correction on every scratch nibble that is 5 or more, ahead of the shift
    always_comb begin
        scratch_adj = scratch_q;
        for (int i = 0; i < 10; i++) begin
            if (scratch_q[i*4 +: 4] >= 4'd5) begin
                scratch_adj[i*4 +: 4] = scratch_q[i*4 +: 4] + 4'd3;
            end
        end
    end

    // Digit codes from the finished scratch, with leading zeros blanked when enabled
    always_comb begin
        for (int i = 0; i < 10; i++) begin
            code_d[i] = {1'b0, scratch_q[i*4 +: 4]};
        end
`ifdef SEV_SEG_BLANK_EN
        begin : blank_scan
            logic lead;
            lead = 1'b1;
            // D1 (index 0) stays visible so a value of zero still shows "0".
            for (int i = 9; i >= 1; i--) begin
                if (lead && (scratch_q[i*4 +: 4] == 4'd0)) begin
                    code_d[i] = 5'h10;
                end else begin
                    lead = 1'b0;
                end
            end
        end
`endif
    end

    // Conversion datapath and output registers; outputs move only on UPDATE
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q     <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            for (int i = 0; i < 10; i++) begin
                dig_q[i] <= '0;
            end
        end else begin
            case (state_q)
                LOAD: begin
                    bin_q     <= ALUoutput;
                    scratch_q <= '0;
                    cnt_q     <= '0;
                end
                SHIFT: begin
                    {scratch_q, bin_q} <= {scratch_adj[38:0], bin_q, 1'b0};
                    cnt_q              <= cnt_q + 5'd1;
                end
                UPDATE: begin
                    for (int i = 0; i < 10; i++) begin
                        dig_q[i] <= code_d[i];
                    end
                end
                default: begin
                    cnt_q <= '0;
                end
            endcase
        end
    end

    assign D1  = dig_q[0];
    assign D2  = dig_q[1];
    assign D3  = dig_q[2];
    assign D4  = dig_q[3];
    assign D5  = dig_q[4];
    assign D6  = dig_q[5];
    assign D7  = dig_q[6];
    assign D8  = dig_q[7];
    assign D9  = dig_q[8];
    assign D10 = dig_q[9];

endmodule

// File: tb/tb_sev_seg_display.sv
// Testbench for sev_seg_display: directed steps with a scoreboard of expected
// digit vectors. Expected values come from a decimal model built on integer
// division, with leading-zero blanking applied when SEV_SEG_BLANK_EN is defined.

module tb_sev_seg_display;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] ALUoutput = '0;
    logic [4:0]  D1, D2, D3, D4, D5, D6, D7, D8, D9, D10;

    int          n_checks = 0;
    int          n_err    = 0;
    logic [49:0] exp_q [$];
    logic [49:0] last_exp = '0;

    sev_seg_display dut (
        .clk       (clk),
        .rst       (rst),
        .ALUoutput (ALUoutput),
        .D1        (D1),
        .D2        (D2),
        .D3        (D3),
        .D4        (D4),
        .D5        (D5),
        .D6        (D6),
        .D7        (D7),
        .D8        (D8),
        .D9        (D9),
        .D10       (D10)
    );

    always #5 clk = ~clk;

    // Reference: decimal digits by division, packed {D10..D1}
    function automatic logic [49:0] model(input logic [31:0] v);
        logic [49:0]     r;
        longint unsigned t;
        logic [3:0]      d [10];
        t = longint'(v);
        for (int i = 0; i < 10; i++) begin
            d[i] = 4'(t % 10);
            t    = t / 10;
        end
        r = '0;
        for (int i = 0; i < 10; i++) begin
            r[i*5 +: 5] = {1'b0, d[i]};
        end
`ifdef SEV_SEG_BLANK_EN
        begin : blank_model
            bit lead;
            lead = 1'b1;
            for (int i = 9; i >= 1; i--) begin
                if (lead && d[i] == 4'd0) r[i*5 +: 5] = 5'h10;
                else lead = 1'b0;
            end
        end
`endif
        return r;
    endfunction

    function automatic logic [49:0] dut_digits();
        return {D10, D9, D8, D7, D6, D5, D4, D3, D2, D1};
    endfunction

    task automatic check(input string tag, input logic [49:0] obs, input logic [49:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called just after the LOAD edge minus 'pre' already-elapsed edges:
    // outputs must hold through edge 32 and update on edge 33 of the period.
    task automatic expect_update(input string tag, input int pre);
        logic [49:0] e;
        tick(33 - pre);
        check({tag, "_hold"}, dut_digits(), last_exp);
        tick(1);
        if (exp_q.size() == 0) begin
            n_checks++;
            n_err++;
            $error("FAIL %s observed=empty_scoreboard expected=entry", tag);
        end else begin
            e = exp_q.pop_front();
            check(tag, dut_digits(), e);
            last_exp = e;
        end
    endtask

    task automatic convert(input string tag, input logic [31:0] v);
        ALUoutput = v;
        exp_q.push_back(model(v));
        expect_update(tag, 0);
    endtask

    initial begin
        rst       = 1'b1;
        ALUoutput = 32'd999;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("reset_zero", dut_digits(), 50'd0);
        end

        rst = 1'b0;
        exp_q.push_back(model(32'd999));
        last_exp = '0;
        expect_update("u999", 0);

        convert("u12345", 32'd12345);
        convert("u0", 32'd0);
        convert("uffffffff", 32'hFFFF_FFFF);
        check("ffffffff_const", dut_digits(),
              {5'd4, 5'd2, 5'd9, 5'd4, 5'd9, 5'd6, 5'd7, 5'd2, 5'd9, 5'd5});
        convert("u1005", 32'd1005);

        ALUoutput = 32'd12345;
        exp_q.push_back(model(32'd12345));
        tick(11);
        ALUoutput = 32'd678;
        exp_q.push_back(model(32'd678));
        expect_update("midchg_old", 11);
        expect_update("midchg_new", 0);

        ALUoutput = 32'd987654321;
        tick(15);
        rst = 1'b1;
        tick(1);
        check("rst_mid_zero", dut_digits(), 50'd0);
        last_exp = '0;
        rst = 1'b0;
        exp_q.push_back(model(32'd987654321));
        expect_update("after_rst", 0);

        convert("u4000000000", 32'd4000000000);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
